// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator: H/V segment FSMs with registered sync/de/coordinates.
// Define VGA_TIMING_RELOAD_EN to build the runtime shadow-register reload path.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_sel,
  input  logic [10:0] cfg_data,
  input  logic        cfg_apply,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
);

  typedef enum logic [1:0] {StActive = 2'd0, StFront = 2'd1, StSync = 2'd2, StBack = 2'd3} seg_e;

  localparam logic [10:0] HDef [4] = '{11'(H_ACTIVE), 11'(H_FRONT), 11'(H_SYNC), 11'(H_BACK)};
  localparam logic [9:0]  VDef [4] = '{10'(V_ACTIVE), 10'(V_FRONT), 10'(V_SYNC), 10'(V_BACK)};

  logic [10:0] h_len [4];
  logic [9:0]  v_len [4];

  seg_e        h_state_q, h_state_d, v_state_q, v_state_d;
  logic [10:0] h_cnt_q, h_cnt_d, h_last;
  logic [9:0]  v_cnt_q, v_cnt_d, v_last;
  logic        line_end, frame_end, first_col;

`ifdef VGA_TIMING_RELOAD_EN
  logic [10:0] h_shd_q [4];
  logic [9:0]  v_shd_q [4];
  logic [10:0] h_act_q [4];
  logic [9:0]  v_act_q [4];
  logic        pending_q;
  logic        cfg_wr;

  assign cfg_ready = ~pending_q;
  assign cfg_wr    = cfg_valid & ~pending_q;

  // Writes are blocked while pending, so the commit never races a shadow write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        h_shd_q[i] <= HDef[i];
        v_shd_q[i] <= VDef[i];
        h_act_q[i] <= HDef[i];
        v_act_q[i] <= VDef[i];
      end
      pending_q <= 1'b0;
    end else begin
      if (cfg_wr) begin
        if (cfg_sel[2]) v_shd_q[cfg_sel[1:0]] <= cfg_data[9:0];
        else            h_shd_q[cfg_sel[1:0]] <= cfg_data;
      end
      if (pending_q && frame_end) begin
        h_act_q   <= h_shd_q;
        v_act_q   <= v_shd_q;
        pending_q <= 1'b0;
      end else if (cfg_apply) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign h_len = h_act_q;
  assign v_len = v_act_q;
`else
  logic unused_cfg;

  assign h_len      = HDef;
  assign v_len      = VDef;
  assign cfg_ready  = 1'b0;
  assign unused_cfg = ^{cfg_valid, cfg_sel, cfg_data, cfg_apply};
`endif

  // A zero length behaves as one: the last index is then 0.
  always_comb begin
    h_last = (h_len[h_state_q] == 11'd0) ? 11'd0 : h_len[h_state_q] - 11'd1;
    v_last = (v_len[v_state_q] == 10'd0) ? 10'd0 : v_len[v_state_q] - 10'd1;
  end

  assign line_end  = pix_en && (h_state_q == StBack) && (h_cnt_q == h_last);
  assign frame_end = line_end && (v_state_q == StBack) && (v_cnt_q == v_last);
  assign first_col = (h_state_q == StActive) && (h_cnt_q == 11'd0);

  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == h_last) begin
        h_cnt_d   = 11'd0;
        h_state_d = seg_e'(h_state_q + 2'd1);
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
    if (line_end) begin
      if (v_cnt_q == v_last) begin
        v_cnt_d   = 10'd0;
        v_state_d = seg_e'(v_state_q + 2'd1);
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state_q <= StActive;
      v_state_q <= StActive;
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 10'd0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Outputs capture the pixel consumed on each strobe and hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= 11'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && first_col;
      frame_start <= pix_en && first_col && (v_state_q == StActive) && (v_cnt_q == 10'd0);
      if (pix_en) begin
        hsync <= (h_state_q == StSync) ? HSYNC_POL : ~HSYNC_POL;
        vsync <= (v_state_q == StSync) ? VSYNC_POL : ~VSYNC_POL;
        de    <= (h_state_q == StActive) && (v_state_q == StActive);
        x     <= (h_state_q == StActive) ? h_cnt_q : 11'd0;
        y     <= (v_state_q == StActive) ? v_cnt_q : 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a raster-position model predicts every registered output.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HF = 4, HS = 6, HB = 3;
  localparam int unsigned VA = 8, VF = 2, VS = 3, VB = 2;
  localparam bit HP = 1'b0, VP = 1'b1;
`ifdef VGA_TIMING_RELOAD_EN
  localparam bit Reload = 1'b1;
`else
  localparam bit Reload = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, cfg_valid = 1'b0, cfg_apply = 1'b0;
  logic [2:0]  cfg_sel = 3'd0;
  logic [10:0] cfg_data = 11'd0;
  logic        cfg_ready, hsync, vsync, de, line_start, frame_start;
  logic [10:0] x;
  logic [9:0]  y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_apply(cfg_apply), .hsync(hsync),
    .vsync(vsync), .de(de), .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // {cfg_ready, hsync, vsync, de, line_start, frame_start, x, y}
  typedef logic [26:0] obs_t;
  obs_t sb_q[$];
  obs_t held;
  int   checks = 0, errors = 0;
  int   de_cnt, hs_cnt, vs_cnt, fs_cnt;

  int unsigned m_h[4], m_v[4], s_h[4], s_v[4];
  int unsigned hpos, vpos;
  bit          m_pend;

  function automatic int unsigned eff(input int unsigned l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic obs_t pixel_exp();
    int unsigned ha, hsb, hse, va, vsb, vse;
    logic hs_o, vs_o, de_o;
    logic [10:0] x_o;
    logic [9:0] y_o;
    ha   = eff(m_h[0]);
    hsb  = ha + eff(m_h[1]);
    hse  = hsb + eff(m_h[2]);
    va   = eff(m_v[0]);
    vsb  = va + eff(m_v[1]);
    vse  = vsb + eff(m_v[2]);
    hs_o = (hpos >= hsb && hpos < hse) ? HP : ~HP;
    vs_o = (vpos >= vsb && vpos < vse) ? VP : ~VP;
    de_o = (hpos < ha) && (vpos < va);
    x_o  = (hpos < ha) ? 11'(hpos) : 11'd0;
    y_o  = (vpos < va) ? 10'(vpos) : 10'd0;
    return {1'b0, hs_o, vs_o, de_o, hpos == 0, (hpos == 0) && (vpos == 0), x_o, y_o};
  endfunction

  function automatic int unsigned htot();
    return eff(m_h[0]) + eff(m_h[1]) + eff(m_h[2]) + eff(m_h[3]);
  endfunction

  function automatic int unsigned vtot();
    return eff(m_v[0]) + eff(m_v[1]) + eff(m_v[2]) + eff(m_v[3]);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic sample_and_compare(input string tag);
    obs_t e, o;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = {cfg_ready, hsync, vsync, de, line_start, frame_start, x, y};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    if (de === 1'b1) de_cnt++;
    if (hsync === HP) hs_cnt++;
    if (vsync === VP) vs_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic step(input bit pe, input bit v = 1'b0, input logic [2:0] sel = 3'd0,
                      input logic [10:0] d = 11'd0, input bit ap = 1'b0);
    obs_t e;
    int unsigned ht, vt;
    pix_en = pe; cfg_valid = v; cfg_sel = sel; cfg_data = d; cfg_apply = ap;
    if (pe) e = pixel_exp();
    else    e = held & ~(obs_t'(3) << 21);
    ht = htot();
    vt = vtot();
    if (Reload) begin
      if (v && !m_pend) begin
        if (sel[2]) s_v[sel[1:0]] = int'(d[9:0]);
        else        s_h[sel[1:0]] = int'(d);
      end
      if (pe && hpos == ht - 1 && vpos == vt - 1 && m_pend) begin
        m_h = s_h; m_v = s_v; m_pend = 1'b0;
      end else if (ap) begin
        m_pend = 1'b1;
      end
    end
    if (pe) begin
      hpos++;
      if (hpos == ht) begin
        hpos = 0;
        vpos++;
        if (vpos == vt) vpos = 0;
      end
    end
    e[26] = Reload && !m_pend;
    held = e;
    sb_q.push_back(e);
    sample_and_compare("raster");
  endtask

  task automatic reset_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      rst_n = 1'b0; pix_en = 1'b1; cfg_valid = 1'b0; cfg_apply = 1'b0;
      m_h = '{HA, HF, HS, HB}; m_v = '{VA, VF, VS, VB};
      s_h = m_h; s_v = m_v; m_pend = 1'b0; hpos = 0; vpos = 0;
      e = {Reload, ~HP, ~VP, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0};
      held = e;
      sb_q.push_back(e);
      sample_and_compare("reset");
    end
    rst_n = 1'b1;
  endtask

  task automatic clr_counts();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
  endtask

  task automatic run_to_frame_end();
    for (int i = 0; i < 3000 && !(hpos == 0 && vpos == 0); i++) step(1'b1);
  endtask

  initial begin
    reset_cycles(3);
    chk("reset_cfg_ready", int'(cfg_ready), int'(Reload));

    // Continuous strobe: one full frame from reset.
    clr_counts();
    repeat (435) step(1'b1);
    chk("de_per_frame", de_cnt, HA * VA);
    chk("hsync_pix_per_frame", hs_cnt, HS * 15);
    chk("vsync_pix_per_frame", vs_cnt, VS * 29);
    chk("frame_start_count", fs_cnt, 1);

    // Strobe every 4th clock: outputs held in between.
    clr_counts();
    repeat (435) begin
      step(1'b1);
      repeat (3) step(1'b0);
    end
    chk("de_clks_slow", de_cnt, HA * VA * 4);
    chk("hsync_clks_slow", hs_cnt, HS * 15 * 4);
    chk("frame_start_slow", fs_cnt, 1);

`ifdef VGA_TIMING_RELOAD_EN
    repeat (100) step(1'b1);
    step(1'b1, 1'b1, 3'd0, 11'd5, 1'b0);
    step(1'b1, 1'b0, 3'd0, 11'd0, 1'b1);
    step(1'b1, 1'b1, 3'd0, 11'd9, 1'b1);
    chk("ready_while_pending", int'(cfg_ready), 0);
    run_to_frame_end();
    clr_counts();
    repeat (18 * 15) step(1'b1);
    chk("de_after_reload", de_cnt, 5 * VA);
    chk("frame_start_reload", fs_cnt, 1);
    // Zero sync lengths; the second write arrives with the apply pulse.
    step(1'b1, 1'b1, 3'd2, 11'd0, 1'b0);
    step(1'b1, 1'b1, 3'd6, 11'd0, 1'b1);
    run_to_frame_end();
    clr_counts();
    repeat (13 * 13) step(1'b1);
    chk("hsync_zero_len", hs_cnt, 13);
    chk("vsync_zero_len", vs_cnt, 13);
    step(1'b1, 1'b1, 3'd0, 11'd3, 1'b1);
`else
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 3'(i), 11'(i), i[0]);
    run_to_frame_end();
    clr_counts();
    for (int i = 0; i < 435; i++) step(1'b1, 1'b1, 3'(i), 11'd1, i[1]);
    chk("de_ignored_cfg", de_cnt, HA * VA);
    chk("ready_tied_low", int'(cfg_ready), 0);
`endif

    // Mid-frame reset, then restart from pixel (0,0) on the first strobe.
    for (int i = 0; i < 3000 && !(vpos == 5 && hpos == 10); i++) step(1'b1);
    reset_cycles(1);
    chk("reset_de", int'(de), 0);
    clr_counts();
    step(1'b1);
    chk("first_frame_start", int'(frame_start), 1);
    chk("first_xy", int'({x, y}), 0);
    repeat (434) step(1'b1);
    chk("de_after_reset", de_cnt, HA * VA);
    chk("fs_after_reset", fs_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
